// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM receive front end: FSM states, packet error codes
// and the FFT-length encoding expected by the FFT wrapper.
package ofdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_PAYLOAD,
    ST_FLUSH
  } cp_state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_TRUNC = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

  localparam int FFT_LEN_DEF = 128;
  localparam int CP_LEN_DEF  = 32;

  // The FFT wrapper takes the transform length as a plain 8-bit point count.
  function automatic logic [7:0] fftpts_enc(input int len);
    return len[7:0];
  endfunction

endpackage

// File: rtl/ofdm_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible while not empty.
// Full is taken from the registered count, so a push is refused when full even if a pop coincides.
module ofdm_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_cp_remove.sv
// Strips the cyclic prefix from each OFDM symbol and hands the FFT_LEN payload samples
// to the FFT as one sop/eop packet, closing broken packets with a tagged terminator.
module ofdm_cp_remove
  import ofdm_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int FFT_LEN    = FFT_LEN_DEF,
  parameter int CP_LEN     = CP_LEN_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sym_start,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_error,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [7:0]        fftpts_out,
  output logic              inverse,
  output logic              overflow,
  input  logic              clr_status,
  output logic [15:0]       sym_cnt
);

  localparam int ENTRY_W = 2*DATA_W + 4;
  localparam int CNT_W   = 16;
  localparam logic [CNT_W-1:0] CP_LAST     = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST    = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] RESTART_CNT = (CP_LEN == 1) ? '0 : CNT_W'(1);
  localparam cp_state_t        RESTART_ST  = (CP_LEN == 1) ? ST_PAYLOAD : ST_SKIP;

  cp_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               push, push_sop, push_eop;
  logic [1:0]         push_err;
  logic [DATA_W-1:0]  push_real, push_imag;
  logic               ovf_set, sym_inc;
  logic               full, empty;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A strobe restarts the symbol from any state except FLUSH; a terminator is only
  // pushed when the interrupted packet already carries a sop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    push_sop  = 1'b0;
    push_eop  = 1'b0;
    push_err  = ERR_OK;
    push_real = '0;
    push_imag = '0;
    ovf_set   = 1'b0;
    sym_inc   = 1'b0;
    if (state == ST_FLUSH) begin
      if (!full) begin
        push      = 1'b1;
        push_eop  = 1'b1;
        push_err  = ERR_OVF;
        sym_inc   = 1'b1;
        state_nxt = ST_IDLE;
      end
    end else if (in_valid) begin
      if (in_sym_start) begin
        state_nxt = RESTART_ST;
        cnt_nxt   = RESTART_CNT;
        if (state == ST_PAYLOAD && cnt != '0) begin
          if (!full) begin
            push     = 1'b1;
            push_eop = 1'b1;
            push_err = ERR_TRUNC;
            sym_inc  = 1'b1;
          end else begin
            ovf_set   = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end
      end else begin
        case (state)
          ST_SKIP: begin
            if (cnt == CP_LAST) begin
              state_nxt = ST_PAYLOAD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          ST_PAYLOAD: begin
            if (full) begin
              ovf_set   = 1'b1;
              state_nxt = (cnt == '0) ? ST_IDLE : ST_FLUSH;
            end else begin
              push      = 1'b1;
              push_sop  = (cnt == '0);
              push_eop  = (cnt == PAY_LAST);
              push_real = in_real;
              push_imag = in_imag;
              if (cnt == PAY_LAST) begin
                sym_inc   = 1'b1;
                state_nxt = ST_IDLE;
              end else begin
                cnt_nxt = cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  ofdm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_sop, push_eop, push_err, push_real, push_imag}),
    .pop       (out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Fields are forced to zero while empty so stale memory never shows on the bus.
  always_comb begin
    out_valid = !empty;
    {out_sop, out_eop, out_error, out_real, out_imag} = empty ? '0 : head;
  end

  assign fftpts_out = fftpts_enc(FFT_LEN);
  assign inverse    = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      sym_cnt  <= '0;
    end else if (clr_status) begin
      overflow <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (sym_inc) sym_cnt  <= sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Randomized bench for ofdm_cp_remove, checked against a symbol-position model
// with a queue standing in for the output FIFO.
module tb_ofdm_cp_remove;

  localparam int DATA_W  = 12;
  localparam int FFT_LEN = 128;
  localparam int CP_LEN  = 32;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sym_start = 1'b0;
  logic [DATA_W-1:0] in_real = '0;
  logic [DATA_W-1:0] in_imag = '0;
  logic              out_ready = 1'b0;
  logic              clr_status = 1'b0;
  logic              out_valid, out_sop, out_eop, inverse, overflow;
  logic [1:0]        out_error;
  logic [DATA_W-1:0] out_real, out_imag;
  logic [7:0]        fftpts_out;
  logic [15:0]       sym_cnt;

  always #5 clk = ~clk;

  ofdm_cp_remove #(
    .DATA_W     (DATA_W),
    .FFT_LEN    (FFT_LEN),
    .CP_LEN     (CP_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_sym_start (in_sym_start),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_error    (out_error),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .fftpts_out   (fftpts_out),
    .inverse      (inverse),
    .overflow     (overflow),
    .clr_status   (clr_status),
    .sym_cnt      (sym_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: position of the next sample inside the current symbol (-1 = none),
  // a pending overflow terminator, and the expected FIFO contents in order.
  logic [27:0] exp_q[$];
  int          sym_pos = -1;
  bit          pending_ovf = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_sym_cnt = '0;

  int          dut_pops, dut_trunc, dut_ovft;
  logic [11:0] first_sop_real, last_eop_real;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [27:0] entry(input bit sop, input bit eop, input logic [1:0] err,
                                        input logic [11:0] re, input logic [11:0] im);
    return {sop, eop, err, re, im};
  endfunction

  task automatic modelEdge(input bit v, input bit s, input logic [11:0] re, input logic [11:0] im,
                           input bit rdy, input bit clr);
    bit          room;
    bit          have_push;
    logic [27:0] push_val;
    int          idx;
    room      = exp_q.size() < DEPTH;
    have_push = 1'b0;
    push_val  = '0;
    if (pending_ovf) begin
      if (room) begin
        have_push = 1'b1;
        push_val  = entry(1'b0, 1'b1, 2'b10, '0, '0);
        pending_ovf = 1'b0;
        m_sym_cnt++;
      end
    end else if (v) begin
      if (s) begin
        if (sym_pos > CP_LEN) begin
          if (room) begin
            have_push = 1'b1;
            push_val  = entry(1'b0, 1'b1, 2'b01, '0, '0);
            m_sym_cnt++;
            sym_pos = 1;
          end else begin
            m_ovf = 1'b1;
            pending_ovf = 1'b1;
            sym_pos = -1;
          end
        end else begin
          sym_pos = 1;
        end
      end else if (sym_pos >= 0 && sym_pos < CP_LEN) begin
        sym_pos++;
      end else if (sym_pos >= CP_LEN) begin
        idx = sym_pos - CP_LEN;
        if (room) begin
          have_push = 1'b1;
          push_val  = entry(idx == 0, idx == FFT_LEN-1, 2'b00, re, im);
          if (idx == FFT_LEN-1) begin
            m_sym_cnt++;
            sym_pos = -1;
          end else begin
            sym_pos++;
          end
        end else begin
          m_ovf = 1'b1;
          pending_ovf = (idx != 0);
          sym_pos = -1;
        end
      end
    end
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (have_push) exp_q.push_back(push_val);
    if (clr) begin
      m_ovf = 1'b0;
      m_sym_cnt = '0;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input logic [11:0] re, input logic [11:0] im,
                               input bit rdy, input bit clr);
    in_valid     = v;
    in_sym_start = s;
    in_real      = re;
    in_imag      = im;
    out_ready    = rdy;
    clr_status   = clr;
    if (out_valid && rdy) begin
      dut_pops++;
      if (out_error == 2'b01) dut_trunc++;
      if (out_error == 2'b10) dut_ovft++;
      if (out_sop) first_sop_real = out_real;
      if (out_eop && out_error == 2'b00) last_eop_real = out_real;
    end
    @(posedge clk);
    #1;
    modelEdge(v, s, re, im, rdy, clr);
    checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      checkOutput("head", 32'({out_sop, out_eop, out_error, out_real, out_imag}), 32'(exp_q[0]));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("sym_cnt", 32'(sym_cnt), 32'(m_sym_cnt));
  endtask

  // n valid samples; base >= 0 gives a ramp on the real part, otherwise random data.
  task automatic feedSamples(input int n, input bit strobe_first, input bit rdy, input int valid_pct, input int base);
    logic [11:0] re;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 8 && $urandom_range(99) >= valid_pct; g++)
        applyStimulus(1'b0, 1'b0, '0, '0, rdy, 1'b0);
      re = (base >= 0) ? 12'(base + i) : 12'($urandom);
      applyStimulus(1'b1, strobe_first && i == 0, re, 12'($urandom), rdy, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic clearCounts();
    dut_pops = 0;
    dut_trunc = 0;
    dut_ovft = 0;
    first_sop_real = '0;
    last_eop_real = '0;
  endtask

  initial begin
    clearCounts();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'({out_sop, out_eop, out_error, out_real, out_imag}), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_sym_cnt", 32'(sym_cnt), 32'd0);
    checkOutput("fftpts", 32'(fftpts_out), 32'd128);
    checkOutput("inverse", 32'(inverse), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] test 1: single clean symbol");
    feedSamples(CP_LEN + FFT_LEN, 1'b1, 1'b1, 100, 0);
    drain(4);
    checkOutput("t1_pops", 32'(dut_pops), 32'd128);
    checkOutput("t1_sop_real", 32'(first_sop_real), 32'd32);
    checkOutput("t1_eop_real", 32'(last_eop_real), 32'd159);
    checkOutput("t1_sym_cnt", 32'(sym_cnt), 32'd1);
    checkOutput("t1_overflow", 32'(overflow), 32'd0);

    $display("[TB] test 2: two symbols with valid gaps");
    clearCounts();
    feedSamples(CP_LEN + FFT_LEN, 1'b1, 1'b1, 50, -1);
    feedSamples(CP_LEN + FFT_LEN, 1'b1, 1'b1, 50, -1);
    drain(4);
    checkOutput("t2_pops", 32'(dut_pops), 32'd256);
    checkOutput("t2_trunc", 32'(dut_trunc), 32'd0);

    $display("[TB] test 3: early strobe truncates packet");
    clearCounts();
    feedSamples(CP_LEN + 40, 1'b1, 1'b1, 100, -1);
    feedSamples(CP_LEN + FFT_LEN, 1'b1, 1'b1, 100, -1);
    drain(4);
    checkOutput("t3_pops", 32'(dut_pops), 32'd169);
    checkOutput("t3_trunc", 32'(dut_trunc), 32'd1);

    $display("[TB] test 4: backpressure overflow mid-payload");
    clearCounts();
    feedSamples(CP_LEN + 10, 1'b1, 1'b1, 100, -1);
    feedSamples(30, 1'b0, 1'b0, 100, -1);
    feedSamples(FFT_LEN - 40, 1'b0, 1'b1, 100, -1);
    drain(20);
    checkOutput("t4_pops", 32'(dut_pops), 32'd26);
    checkOutput("t4_ovf_term", 32'(dut_ovft), 32'd1);
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("t4_clr", 32'({overflow, sym_cnt}), 32'd0);

    $display("[TB] test 5: FIFO full at the sop sample");
    clearCounts();
    feedSamples(CP_LEN + 15, 1'b1, 1'b0, 100, -1);
    feedSamples(CP_LEN, 1'b1, 1'b0, 100, -1);
    feedSamples(1, 1'b0, 1'b0, 100, -1);
    feedSamples(FFT_LEN - 1, 1'b0, 1'b1, 100, -1);
    drain(20);
    checkOutput("t5_pops", 32'(dut_pops), 32'd16);
    checkOutput("t5_trunc", 32'(dut_trunc), 32'd1);
    checkOutput("t5_ovf_term", 32'(dut_ovft), 32'd0);
    checkOutput("t5_overflow", 32'(overflow), 32'd1);

    $display("[TB] test 6: reset mid-payload");
    clearCounts();
    feedSamples(CP_LEN + 50, 1'b1, 1'b1, 100, -1);
    feedSamples(5, 1'b0, 1'b0, 100, -1);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    in_sym_start = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_data", 32'({out_sop, out_eop, out_error, out_real, out_imag}), 32'd0);
    checkOutput("t6_rst_status", 32'({overflow, sym_cnt}), 32'd0);
    exp_q.delete();
    sym_pos = -1;
    pending_ovf = 1'b0;
    m_ovf = 1'b0;
    m_sym_cnt = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    clearCounts();
    feedSamples(CP_LEN + FFT_LEN, 1'b1, 1'b1, 100, -1);
    drain(4);
    checkOutput("t6_pops", 32'(dut_pops), 32'd128);
    checkOutput("t6_sym_cnt", 32'(sym_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
